// File: rtl/spu_ls_loader_pkg.sv
// Shared types and constants for the SPU local-store program loader.
package spu_ls_loader_pkg;

  // Loader sequencing: accept words, flush a quadword, hold the core in
  // reset for a few cycles, then let it run. ERR is terminal until reset.
  typedef enum logic [2:0] {
    LD_LOAD  = 3'd0,
    LD_WRITE = 3'd1,
    LD_HOLD  = 3'd2,
    LD_RUN   = 3'd3,
    LD_ERR   = 3'd4
  } ld_state_e;

  localparam int QW_BYTES     = 16;
  localparam int WORDS_PER_QW = 4;
  localparam int WORD_W       = 32;
  localparam int QW_W         = 128;

  // Insert a 32-bit word into slot 'slot' of a quadword. Slots are counted
  // big-endian: slot 0 is the most significant word, which is the first
  // instruction the SPU fetches from the quadword.
  function automatic logic [QW_W-1:0] put_slot(
    input logic [QW_W-1:0]   qw,
    input logic [1:0]        slot,
    input logic [WORD_W-1:0] word
  );
    logic [QW_W-1:0] r;
    int              lsb;
    r   = qw;
    lsb = (WORDS_PER_QW - 1 - int'(slot)) * WORD_W;
    r[lsb +: WORD_W] = word;
    return r;
  endfunction

endpackage

// File: rtl/spu_ls_loader_if.sv
// Host word stream plus local-store write port and core control of the loader.
//
// Handshake: a host word (host_data, host_last) transfers on every rising
// clock edge where host_valid and host_ready are both high. The host must
// hold host_data/host_last stable while host_valid is high and host_ready is
// low; host_ready never depends combinationally on host_valid. ls_wr_en is a
// one-cycle strobe with no back-pressure: ls_addr/ls_data_wr are valid only
// in the cycle it is high.
interface spu_ls_loader_if;
  import spu_ls_loader_pkg::*;

  logic              host_valid;
  logic [WORD_W-1:0] host_data;
  logic              host_last;
  logic              host_ready;
  logic [31:0]       ls_addr;
  logic [QW_W-1:0]   ls_data_wr;
  logic              ls_wr_en;
  logic              core_rst;
  logic              ld_done;
  logic              ld_err;

  // Loader side.
  modport slave (
    input  host_valid, host_data, host_last,
    output host_ready, ls_addr, ls_data_wr, ls_wr_en, core_rst, ld_done, ld_err
  );

  // Host / environment side.
  modport master (
    output host_valid, host_data, host_last,
    input  host_ready, ls_addr, ls_data_wr, ls_wr_en, core_rst, ld_done, ld_err
  );
endinterface

// File: rtl/spu_ls_loader.sv
// Program loader: packs host instruction words into quadwords, writes them
// to local store from BASE_ADDR upward, then releases the SPU core reset.
module spu_ls_loader
  import spu_ls_loader_pkg::*;
#(
  parameter int LS_SIZE_BYTES = 32768,
  parameter int BASE_ADDR     = 0,
  parameter int CORE_RST_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,        // asynchronous, active low
  spu_ls_loader_if.slave bus,
  output ld_state_e      dbg_state
);

  localparam logic [31:0] LS_LIMIT  = 32'(LS_SIZE_BYTES);
  localparam logic [31:0] ADDR_INIT = 32'(BASE_ADDR);
  localparam logic [31:0] ADDR_STEP = 32'(QW_BYTES);
  localparam logic [3:0]  HOLD_INIT = 4'(CORE_RST_HOLD);
  localparam logic [1:0]  LAST_SLOT = 2'(WORDS_PER_QW - 1);

  ld_state_e       state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [QW_W-1:0] pack_q, pack_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      hold_q, hold_d;
  // Remembers that the group being packed holds the program's last word.
  logic            last_q, last_d;
  // Registered so host_ready is low while reset is asserted and during the
  // first cycle after release, and never combinational on host inputs.
  logic            ready_q, ready_d;

  logic            accept;

  assign accept = bus.host_valid & ready_q;

  // State and datapath registers; reset restores the idle loader.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LD_LOAD;
      wcnt_q  <= '0;
      pack_q  <= '0;
      addr_q  <= ADDR_INIT;
      hold_q  <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pack_q  <= pack_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and datapath updates for the load / write / hold sequence.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pack_d  = pack_q;
    addr_d  = addr_q;
    hold_d  = hold_q;
    last_d  = last_q;

    case (state_q)
      LD_LOAD: begin
        if (accept) begin
          // The quadword this word would land in starts beyond the store:
          // the program does not fit, so stop without writing anything more.
          // A group ending exactly at LS_SIZE_BYTES starts below the limit.
          if (addr_q >= LS_LIMIT) begin
            state_d = LD_ERR;
          end else begin
            pack_d = put_slot(pack_q, wcnt_q, bus.host_data);
            wcnt_d = wcnt_q + 2'd1;
            last_d = bus.host_last;
            if (wcnt_q == LAST_SLOT || bus.host_last) begin
              state_d = LD_WRITE;
            end
          end
        end
      end

      LD_WRITE: begin
        // Strobe happens this cycle; unfilled slots were never written and
        // stay zero, which the SPU decodes as stop.
        pack_d = '0;
        wcnt_d = '0;
        last_d = 1'b0;
        addr_d = addr_q + ADDR_STEP;
        if (last_q) begin
          state_d = LD_HOLD;
          hold_d  = HOLD_INIT;
        end else begin
          state_d = LD_LOAD;
        end
      end

      LD_HOLD: begin
        // Core reset stays asserted for HOLD_INIT cycles after the final write.
        hold_d = hold_q - 4'd1;
        if (hold_q <= 4'd1) begin
          state_d = LD_RUN;
          hold_d  = '0;
        end
      end

      LD_RUN: state_d = LD_RUN;

      LD_ERR: state_d = LD_ERR;

      default: state_d = LD_ERR;
    endcase

    ready_d = (state_d == LD_LOAD);
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    bus.host_ready = ready_q;
    bus.ls_addr    = addr_q;
    bus.ls_wr_en   = (state_q == LD_WRITE);
    bus.ls_data_wr = (state_q == LD_WRITE) ? pack_q : '0;
    bus.core_rst   = (state_q != LD_RUN);
    bus.ld_done    = (state_q == LD_RUN);
    bus.ld_err     = (state_q == LD_ERR);
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_spu_ls_loader.sv
// Self-checking bench for spu_ls_loader: directed and random programs,
// expected local-store writes queued by a reference model, checked by a
// monitor whenever the loader strobes a write.
module tb_spu_ls_loader;
  import spu_ls_loader_pkg::*;

  localparam int LS   = 32;
  localparam int BASE = 0;
  localparam int HOLD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  spu_ls_loader_if bus ();
  ld_state_e dbg_state;

  spu_ls_loader #(
    .LS_SIZE_BYTES(LS),
    .BASE_ADDR    (BASE),
    .CORE_RST_HOLD(HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [159:0] exp_q[$];     // {addr, data} of each expected write
  logic [31:0]  prog_q[$];    // program under test
  int n_cmp = 0;
  int n_err = 0;
  int last_wr_cyc = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.ls_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.ls_addr, bus.ls_data_wr);
      end else begin
        check("ls_write", {bus.ls_addr, bus.ls_data_wr}, exp_q.pop_front());
      end
      last_wr_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values();
    check("rst_host_ready", bus.host_ready, 1'b0);
    check("rst_ls_addr",    bus.ls_addr, BASE);
    check("rst_ls_data",    bus.ls_data_wr, '0);
    check("rst_ls_wr_en",   bus.ls_wr_en, 1'b0);
    check("rst_core_rst",   bus.core_rst, 1'b1);
    check("rst_ld_done",    bus.ld_done, 1'b0);
    check("rst_ld_err",     bus.ld_err, 1'b0);
  endtask

  // Asserts reset between clock edges and checks outputs respond at once.
  task automatic do_reset();
    @(negedge clk);
    bus.host_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Offers prog_q[0..count-1] until each is accepted. mode 0: valid always
  // high, 1: random gaps, 2: valid toggling every cycle.
  task automatic drive_words(input int count, input bit with_last, input int mode, output bit ok);
    int i;
    int waitc;
    bit v;
    bit tog;
    ok    = 1'b1;
    i     = 0;
    waitc = 0;
    tog   = 1'b1;
    while (i < count) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: begin v = tog; tog = ~tog; end
      endcase
      bus.host_valid = v;
      bus.host_data  = v ? prog_q[i] : $urandom();
      bus.host_last  = v ? (with_last && i == count - 1) : 1'($urandom_range(0, 1));
      if (v && bus.host_ready === 1'b1) begin
        i++;
        waitc = 0;
      end else begin
        waitc++;
        if (waitc > 60) begin
          n_cmp++;
          n_err++;
          $display("FAIL accept_timeout: word %0d got host_ready=%b expected 1 within 60 cycles",
                   i, bus.host_ready);
          ok = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    bus.host_valid = 1'b0;
  endtask

  // Reference model + run: the program is cut into groups of four words in
  // order, zero padded, written at consecutive quadword addresses; words that
  // would start a quadword past the store end trigger the error instead.
  task automatic run_prog(input int mode);
    int n, fit, nw, groups, t;
    logic [127:0] d;
    logic [31:0]  w;
    bit ok, ovf;
    n      = prog_q.size();
    fit    = (LS - BASE) / 4;
    ovf    = (n > fit);
    nw     = ovf ? fit : n;
    groups = (nw + 3) / 4;
    for (int g = 0; g < groups; g++) begin
      d = '0;
      for (int k = 0; k < 4; k++) begin
        w = (4 * g + k < nw) ? prog_q[4 * g + k] : 32'h0;
        d = {d[95:0], w};
      end
      exp_q.push_back({32'(BASE + 16 * g), d});
    end

    if (ovf) drive_words(fit + 1, n == fit + 1, mode, ok);
    else     drive_words(n, 1'b1, mode, ok);
    if (!ok) return;

    if (ovf) begin
      for (t = 0; t < 50 && bus.ld_err !== 1'b1; t++) @(negedge clk);
      check("ovf_ld_err",   bus.ld_err, 1'b1);
      check("ovf_core_rst", bus.core_rst, 1'b1);
      check("ovf_ld_done",  bus.ld_done, 1'b0);
    end else begin
      for (t = 0; t < 100 && bus.ld_done !== 1'b1; t++) @(negedge clk);
      check("run_ld_done",  bus.ld_done, 1'b1);
      check("hold_cycles",  cyc - last_wr_cyc, HOLD + 1);
      check("run_core_rst", bus.core_rst, 1'b0);
      check("run_ld_err",   bus.ld_err, 1'b0);
    end

    // Further host traffic must be ignored in both terminal states.
    repeat (5) begin
      @(negedge clk);
      bus.host_valid = 1'b1;
      bus.host_data  = $urandom();
      bus.host_last  = 1'($urandom_range(0, 1));
    end
    check("post_host_ready", bus.host_ready, 1'b0);
    @(negedge clk);
    bus.host_valid = 1'b0;
    check("pending_writes", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    bus.host_valid = 1'b0;
    bus.host_data  = '0;
    bus.host_last  = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_values();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 8 sequential words: two full quadwords.
    prog_q.delete();
    for (int i = 1; i <= 8; i++) prog_q.push_back(32'(i));
    run_prog(0);

    // 5 words: second quadword is {w5, 0, 0, 0}.
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 5; i++) prog_q.push_back($urandom());
    run_prog(0);

    // Single word with last on the first beat.
    do_reset();
    prog_q.delete();
    prog_q.push_back(32'h40200000);
    run_prog(0);

    // 9 words into a 32-byte store: overflow on the 9th.
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 9; i++) prog_q.push_back($urandom());
    run_prog(0);

    // host_valid toggling each cycle over 4 words.
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 4; i++) prog_q.push_back($urandom());
    run_prog(2);

    // Reset with two words packed: partial group is discarded.
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 2; i++) prog_q.push_back($urandom());
    drive_words(2, 1'b0, 0, ok);
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 4; i++) prog_q.push_back($urandom());
    run_prog(0);

    // Random programs, including overflowing lengths.
    for (int r = 0; r < 10; r++) begin
      do_reset();
      prog_q.delete();
      for (int i = 0, n = $urandom_range(1, 11); i < n; i++) prog_q.push_back($urandom());
      run_prog($urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
